// File: rtl/dfa_fault_sequencer.sv
// Fault-injection campaign sequencer for aes_128_fault: captures a golden ciphertext, then
// injects one single-bit fault per index in [BIT_LO..BIT_HI] and streams each faulty record.
module dfa_fault_sequencer #(
  parameter int unsigned AES_LATENCY = 21,
  parameter int unsigned BIT_LO      = 0,
  parameter int unsigned BIT_HI      = 127
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  output logic         fault_en,
  output logic [6:0]   fault_bit,
  output logic         rec_valid,
  input  logic         rec_ready,
  output logic [6:0]   rec_bit,
  output logic [127:0] rec_ct,
  output logic [127:0] rec_diff,
  output logic [4:0]   rec_nbytes,
  output logic [127:0] golden,
  output logic         busy,
  output logic         done
);

  localparam int unsigned   CW         = $clog2(AES_LATENCY + 1);
  localparam logic [6:0]    IDX_LO     = 7'(BIT_LO);
  localparam logic [6:0]    IDX_HI     = 7'(BIT_HI);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(AES_LATENCY - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(AES_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_GOLD,
    S_INJ,
    S_WAIT,
    S_CAP,
    S_OUT,
    S_FIN
  } state_t;

  state_t        state;
  logic [6:0]    idx;
  logic [CW-1:0] cnt;
  logic [127:0]  diff_now;
  logic [4:0]    nz_now;

  always_comb begin
    diff_now = ciphertext ^ golden;
    nz_now   = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      nz_now = nz_now + {4'd0, |diff_now[b*8 +: 8]};
    end
  end

  // fault_en is registered, so it is raised on the edge that enters INJ (from GOLD or OUT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      fault_en   <= 1'b0;
      fault_bit  <= '0;
      rec_valid  <= 1'b0;
      rec_bit    <= '0;
      rec_ct     <= '0;
      rec_diff   <= '0;
      rec_nbytes <= '0;
      golden     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fault_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= IDX_LO;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state <= S_GOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GOLD: begin
          golden    <= ciphertext;
          fault_en  <= 1'b1;
          fault_bit <= idx;
          state     <= S_INJ;
        end
        S_INJ: begin
          cnt   <= CW'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= S_CAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAP: begin
          rec_ct     <= ciphertext;
          rec_diff   <= diff_now;
          rec_nbytes <= nz_now;
          rec_bit    <= idx;
          rec_valid  <= 1'b1;
          state      <= S_OUT;
        end
        S_OUT: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            if (idx == IDX_HI) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx       <= idx + 7'd1;
              fault_en  <= 1'b1;
              fault_bit <= idx + 7'd1;
              state     <= S_INJ;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfa_fault_sequencer.sv
// Self-checking bench: stub AES core with a fixed-latency fault pipeline, a record/fault model
// derived from the campaign rules, and directed campaigns covering backpressure, resets and ignored starts.
module tb_dfa_fault_sequencer;

  localparam int unsigned  L   = 21;
  localparam logic [127:0] G   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PAT = 128'hFF00FF00_00000000_00000000_000000FF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         start = 1'b0;
  logic [127:0] ciphertext;
  logic         fault_en;
  logic [6:0]   fault_bit;
  logic         rec_valid;
  logic         rec_ready = 1'b1;
  logic [6:0]   rec_bit;
  logic [127:0] rec_ct, rec_diff, golden;
  logic [4:0]   rec_nbytes;
  logic         busy, done;

  logic         start_one = 1'b0;
  logic [127:0] ciphertext_one;
  logic         fault_en_one;
  logic [6:0]   fault_bit_one;
  logic         rec_valid_one;
  logic         rec_ready_one = 1'b1;
  logic [6:0]   rec_bit_one;
  logic [127:0] rec_ct_one, rec_diff_one, golden_one;
  logic [4:0]   rec_nbytes_one;
  logic         busy_one, done_one;

  int unsigned  stub_mode = 0;
  int unsigned  checks = 0, errors = 0;
  int unsigned  rec_count = 0, inj_count = 0, done_count = 0;
  int unsigned  cyc = 0, first_hs = 0, last_hs = 0;
  logic         prev_fe = 1'b0;

  dfa_fault_sequencer #(.AES_LATENCY(L)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ciphertext(ciphertext),
    .fault_en(fault_en), .fault_bit(fault_bit), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_bit(rec_bit), .rec_ct(rec_ct), .rec_diff(rec_diff), .rec_nbytes(rec_nbytes),
    .golden(golden), .busy(busy), .done(done)
  );

  dfa_fault_sequencer #(.AES_LATENCY(L), .BIT_LO(5), .BIT_HI(5)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_one), .ciphertext(ciphertext_one),
    .fault_en(fault_en_one), .fault_bit(fault_bit_one), .rec_valid(rec_valid_one),
    .rec_ready(rec_ready_one), .rec_bit(rec_bit_one), .rec_ct(rec_ct_one),
    .rec_diff(rec_diff_one), .rec_nbytes(rec_nbytes_one), .golden(golden_one),
    .busy(busy_one), .done(done_one)
  );

  initial forever #5 clk = ~clk;

  // Fault mask the stub core applies for a given bit; mode 1 adds multi-byte and masked faults.
  function automatic logic [127:0] fault_mask(input int unsigned mode, input int unsigned b);
    logic [127:0] one;
    one = 128'd1;
    if (mode == 1 && b % 4 == 1) return PAT;
    if (mode == 1 && b % 4 == 2) return '0;
    return one << b;
  endfunction

  function automatic int unsigned nz_count(input logic [127:0] d);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 16; i++) if (d[i*8 +: 8] != 8'h00) n++;
    return n;
  endfunction

  // Stub core: fault pulse enters an input register, then an L-stage pipeline.
  logic [127:0] pipe_a [0:L];
  logic [127:0] pipe_b [0:L];
  always @(posedge clk) begin
    pipe_a[0] <= fault_en ? fault_mask(stub_mode, 32'(fault_bit)) : '0;
    pipe_b[0] <= fault_en_one ? fault_mask(0, 32'(fault_bit_one)) : '0;
    for (int unsigned i = 1; i <= L; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign ciphertext     = G ^ pipe_a[L];
  assign ciphertext_one = G ^ pipe_b[L];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] all_outputs();
    return 512'({fault_en, fault_bit, rec_valid, rec_bit, rec_ct, rec_diff, rec_nbytes,
                 golden, busy, done});
  endfunction

  // Observes the current cycle (outputs after the last edge, inputs about to be sampled).
  task automatic sample();
    logic [127:0] m;
    cyc++;
    if (!rst_n) begin
      prev_fe = 1'b0;
      return;
    end
    if (fault_en) begin
      chk("fault_bit", 512'(fault_bit), 512'(inj_count));
      chk("fault_single_cycle", 512'(prev_fe), 512'(0));
      chk("fault_while_pending", 512'(rec_valid), 512'(0));
      inj_count++;
    end
    prev_fe = fault_en;
    if (rec_valid && rec_ready) begin
      m = fault_mask(stub_mode, rec_count);
      chk("rec_bit", 512'(rec_bit), 512'(rec_count));
      chk("rec_diff", 512'(rec_diff), 512'(m));
      chk("rec_ct", 512'(rec_ct), 512'(G ^ m));
      chk("rec_nbytes", 512'(rec_nbytes), 512'(nz_count(m)));
      if (rec_count == 0) first_hs = cyc;
      last_hs = cyc;
      rec_count++;
    end
    if (done) done_count++;
  endtask

  task automatic step();
    sample();
    @(negedge clk);
  endtask

  task automatic clear_counts();
    rec_count  = 0;
    inj_count  = 0;
    done_count = 0;
    prev_fe    = 1'b0;
  endtask

  task automatic run_until_done(input string tag);
    int unsigned k;
    k = 0;
    while (done !== 1'b1 && k < 5000) begin step(); k++; end
    chk(tag, 512'(done), 512'(1));
  endtask

  task automatic run_until_recs(input int unsigned target, input string tag);
    int unsigned k;
    k = 0;
    while (rec_count < target && k < 2000) begin step(); k++; end
    chk(tag, 512'(rec_count), 512'(target));
  endtask

  task automatic run_until_inj(input int unsigned b, input string tag);
    int unsigned k;
    k = 0;
    while (!(fault_en === 1'b1 && fault_bit == 7'(b)) && k < 5000) begin step(); k++; end
    chk(tag, 512'(fault_en), 512'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int unsigned  n, nrec;
    logic [127:0] s_ct, s_diff;
    logic [6:0]   s_bit;
    logic [4:0]   s_nb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), '0);
    repeat (30) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_outputs", all_outputs(), '0);

    // Single-bit campaign on the BIT_LO=BIT_HI=5 instance, with end-to-end latency
    start_one = 1'b1;
    step();
    start_one = 1'b0;
    chk("one_busy", 512'(busy_one), 512'(1));
    n = 1;
    nrec = 0;
    while (!done_one && n < 200) begin
      if (rec_valid_one) begin
        chk("one_rec_bit", 512'(rec_bit_one), 512'(5));
        chk("one_rec_diff", 512'(rec_diff_one), 512'(128'h20));
        chk("one_rec_ct", 512'(rec_ct_one), 512'(G ^ 128'h20));
        chk("one_rec_nbytes", 512'(rec_nbytes_one), 512'(1));
        nrec++;
      end
      step();
      n++;
    end
    chk("one_done_latency", 512'(n), 512'(1 + L + 1 + 1 + L + 1 + 1));
    chk("one_record_count", 512'(nrec), 512'(1));
    chk("one_golden", 512'(golden_one), 512'(G));
    step();
    chk("one_busy_end", 512'({busy_one, done_one}), 512'(0));

    // Full default campaign with rec_ready held high
    clear_counts();
    stub_mode = 0;
    pulse_start();
    chk("full_busy", 512'(busy), 512'(1));
    run_until_done("full_done_seen");
    chk("full_records", 512'(rec_count), 512'(128));
    repeat (3) step();
    chk("full_done_once", 512'(done_count), 512'(1));
    chk("full_idle", 512'({busy, done, rec_valid, fault_en}), 512'(0));
    chk("full_golden", 512'(golden), 512'(G));
    chk("full_injections", 512'(inj_count), 512'(128));
    chk("full_record_rate", 512'(last_hs - first_hs), 512'(127 * (L + 3)));

    // Patterned diffs, backpressure on record 3, ignored starts during WAIT and FIN
    clear_counts();
    stub_mode = 1;
    pulse_start();
    run_until_recs(3, "bp_reach_rec3");
    rec_ready = 1'b0;
    n = 0;
    while (!rec_valid && n < 100) begin step(); n++; end
    chk("bp_valid_seen", 512'(rec_valid), 512'(1));
    chk("bp_rec_bit", 512'(rec_bit), 512'(3));
    s_bit  = rec_bit;
    s_ct   = rec_ct;
    s_diff = rec_diff;
    s_nb   = rec_nbytes;
    repeat (10) begin
      step();
      chk("bp_hold", 512'({rec_bit, rec_ct, rec_diff, rec_nbytes, rec_valid, fault_en}),
          512'({s_bit, s_ct, s_diff, s_nb, 1'b1, 1'b0}));
    end
    rec_ready = 1'b1;
    run_until_recs(5, "bp_resume");
    run_until_inj(7, "wait_start_inj");
    step();
    step();
    pulse_start();
    chk("wait_start_busy", 512'(busy), 512'(1));
    run_until_done("pat_done_seen");
    pulse_start();
    repeat (40) step();
    chk("pat_records", 512'(rec_count), 512'(128));
    chk("pat_injections", 512'(inj_count), 512'(128));
    chk("pat_done_once", 512'(done_count), 512'(1));
    chk("fin_start_ignored", 512'({busy, fault_en, rec_valid}), 512'(0));

    // Reset during WAIT of bit 40, then a fresh campaign
    clear_counts();
    stub_mode = 0;
    pulse_start();
    run_until_inj(40, "rst_reach_bit40");
    step();
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_fault_en", 512'(fault_en), 512'(0));
    chk("rst_outputs", all_outputs(), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    step();
    chk("rst_idle", all_outputs(), '0);
    pulse_start();
    run_until_done("rerun_done_seen");
    chk("rerun_records", 512'(rec_count), 512'(128));
    repeat (3) step();
    chk("rerun_golden", 512'(golden), 512'(G));
    chk("rerun_done_once", 512'(done_count), 512'(1));
    chk("rerun_injections", 512'(inj_count), 512'(128));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
